rtc_bus_transaction: RTL and testbench

Bus-cycle engine on the RTC side of the sequencing FSM. It accepts one read or write request at a time (enable, w/r, address, write data) and runs the RTC's multiplexed address/data parallel-bus cycle: address phase, then data phase. It returns a one-cycle done pulse, plus captured read data on reads. The sequencing FSM counts the done pulses to step through its address tables. The top level owns the tristate AD pad, using out_ad_bus, out_ad_oe and in_ad_bus.

---
 rtl/rtc_bus_pkg.sv | 22 ++
 rtl/rtc_phase_timer.sv | 34 +++
 rtl/rtc_bus_transaction.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_bus_transaction.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC multiplexed address/data bus engine:
// state encoding, default phase timings and AD-phase polarity.
package rtc_bus_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ADDR_SETUP  = 3'd1;
  localparam logic [2:0] ST_ADDR_STROBE = 3'd2;
  localparam logic [2:0] ST_ADDR_HOLD   = 3'd3;
  localparam logic [2:0] ST_DATA_SETUP  = 3'd4;
  localparam logic [2:0] ST_DATA_STROBE = 3'd5;
  localparam logic [2:0] ST_DATA_HOLD   = 3'd6;
  localparam logic [2:0] ST_DONE        = 3'd7;

  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_PULSE = 5;
  localparam int unsigned DEF_T_HOLD  = 2;

  // Level of the ad_n pin in each half of the bus cycle.
  localparam logic AD_PHASE_ADDR = 1'b0;
  localparam logic AD_PHASE_DATA = 1'b1;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter shared by every bus phase; zero flags the last cycle
// of the current phase.
module rtc_phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rtc_bus_transaction.sv
// Runs one RTC multiplexed-bus read or write cycle (address phase, then data
// phase) per accepted request and pulses out_flag_done when it completes.
module rtc_bus_transaction
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_PULSE = DEF_T_PULSE,
  parameter int unsigned T_HOLD  = DEF_T_HOLD,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en_funcion_rtc,
  input  logic       in_funcion_w_r,
  input  logic [7:0] in_addr_ram_rtc,
  input  logic [7:0] in_dato_escritura,
  input  logic [7:0] in_ad_bus,
  output logic       out_flag_done,
  output logic [7:0] out_dato_leido,
  output logic       out_cs_n,
  output logic       out_rd_n,
  output logic       out_wr_n,
  output logic       out_ad_n,
  output logic [7:0] out_ad_bus,
  output logic       out_ad_oe,
  output logic [2:0] state_now
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  logic [2:0]       state_q, state_d;
  logic             w_r_q, w_r_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;
  logic             capture;

  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             ad_n_q, ad_n_d;
  logic             ad_oe_q, ad_oe_d;
  logic [7:0]       ad_bus_q, ad_bus_d;
  logic             done_q, done_d;
  logic [7:0]       dato_q;

  rtc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  // Sequencing: each phase state lasts until the timer drains, then loads the
  // next phase's length on the same edge it advances.
  always_comb begin
    state_d     = state_q;
    w_r_d       = w_r_q;
    addr_d      = addr_q;
    data_d      = data_q;
    timer_load  = 1'b0;
    timer_value = '0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_en_funcion_rtc) begin
          state_d     = ST_ADDR_SETUP;
          w_r_d       = in_funcion_w_r;
          addr_d      = in_addr_ram_rtc;
          data_d      = in_dato_escritura;
          timer_load  = 1'b1;
          timer_value = LD_SETUP;
        end
      end
      ST_ADDR_SETUP: begin
        if (timer_zero) begin
          state_d     = ST_ADDR_STROBE;
          timer_load  = 1'b1;
          timer_value = LD_PULSE;
        end
      end
      ST_ADDR_STROBE: begin
        if (timer_zero) begin
          state_d     = ST_ADDR_HOLD;
          timer_load  = 1'b1;
          timer_value = LD_HOLD;
        end
      end
      ST_ADDR_HOLD: begin
        if (timer_zero) begin
          state_d     = ST_DATA_SETUP;
          timer_load  = 1'b1;
          timer_value = LD_SETUP;
        end
      end
      ST_DATA_SETUP: begin
        if (timer_zero) begin
          state_d     = ST_DATA_STROBE;
          timer_load  = 1'b1;
          timer_value = LD_PULSE;
        end
      end
      ST_DATA_STROBE: begin
        if (timer_zero) begin
          state_d     = ST_DATA_HOLD;
          timer_load  = 1'b1;
          timer_value = LD_HOLD;
          capture     = ~w_r_q;
        end
      end
      ST_DATA_HOLD: begin
        if (timer_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so they register in step with it.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = AD_PHASE_DATA;
    ad_oe_d  = 1'b0;
    ad_bus_d = '0;
    done_d   = 1'b0;
    case (state_d)
      ST_ADDR_SETUP, ST_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = AD_PHASE_ADDR;
        ad_oe_d  = 1'b1;
        ad_bus_d = addr_d;
      end
      ST_ADDR_STROBE: begin
        cs_n_d   = 1'b0;
        ad_n_d   = AD_PHASE_ADDR;
        ad_oe_d  = 1'b1;
        ad_bus_d = addr_d;
        wr_n_d   = 1'b0;
      end
      ST_DATA_SETUP, ST_DATA_HOLD: begin
        cs_n_d = 1'b0;
        if (w_r_d) begin
          ad_oe_d  = 1'b1;
          ad_bus_d = data_d;
        end
      end
      ST_DATA_STROBE: begin
        cs_n_d = 1'b0;
        if (w_r_d) begin
          ad_oe_d  = 1'b1;
          ad_bus_d = data_d;
          wr_n_d   = 1'b0;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      w_r_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_n_q   <= AD_PHASE_DATA;
      ad_oe_q  <= 1'b0;
      ad_bus_q <= '0;
      done_q   <= 1'b0;
      dato_q   <= '0;
    end else begin
      state_q  <= state_d;
      w_r_q    <= w_r_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ad_n_q   <= ad_n_d;
      ad_oe_q  <= ad_oe_d;
      ad_bus_q <= ad_bus_d;
      done_q   <= done_d;
      if (capture) begin
        dato_q <= in_ad_bus;
      end
    end
  end

  assign out_flag_done  = done_q;
  assign out_dato_leido = dato_q;
  assign out_cs_n       = cs_n_q;
  assign out_rd_n       = rd_n_q;
  assign out_wr_n       = wr_n_q;
  assign out_ad_n       = ad_n_q;
  assign out_ad_bus     = ad_bus_q;
  assign out_ad_oe      = ad_oe_q;
  assign state_now      = state_q;

endmodule

// File: tb/tb_rtc_bus_transaction.sv
// Scoreboard bench: stimulus pushes expected transactions, a pin-level monitor
// rebuilds each bus cycle and checks it against the front of the queue.
module tb_rtc_bus_transaction;

  localparam int S0 = 2, P0 = 5, H0 = 2;
  localparam int S1 = 1, P1 = 1, H1 = 1;

  typedef struct {
    bit       w_r;
    bit [7:0] addr;
    bit [7:0] data;
    bit [7:0] dato;
    int       acc;
    int       lat;
    int       pulse;
    int       phase;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       en0 = 1'b0, wr0 = 1'b0, en1 = 1'b0, wr1 = 1'b0;
  logic [7:0] addr0 = '0, data0 = '0, rdval0 = '0, adin0;
  logic [7:0] addr1 = '0, data1 = '0, rdval1 = '0, adin1;
  logic       done0, csn0, rdn0, wrn0, adn0, oe0;
  logic       done1, csn1, rdn1, wrn1, adn1, oe1;
  logic [7:0] dato0, bus0, dato1, bus1;
  logic [2:0] st0, st1;

  // Device model: drives the read value only while the read strobe is low.
  assign adin0 = rdn0 ? 8'hEE : rdval0;
  assign adin1 = rdn1 ? 8'hEE : rdval1;

  rtc_bus_transaction dut0 (
    .clk(clk), .reset(reset), .in_en_funcion_rtc(en0), .in_funcion_w_r(wr0),
    .in_addr_ram_rtc(addr0), .in_dato_escritura(data0), .in_ad_bus(adin0),
    .out_flag_done(done0), .out_dato_leido(dato0), .out_cs_n(csn0), .out_rd_n(rdn0),
    .out_wr_n(wrn0), .out_ad_n(adn0), .out_ad_bus(bus0), .out_ad_oe(oe0), .state_now(st0)
  );

  rtc_bus_transaction #(
    .T_SETUP(S1), .T_PULSE(P1), .T_HOLD(H1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .reset(reset), .in_en_funcion_rtc(en1), .in_funcion_w_r(wr1),
    .in_addr_ram_rtc(addr1), .in_dato_escritura(data1), .in_ad_bus(adin1),
    .out_flag_done(done1), .out_dato_leido(dato1), .out_cs_n(csn1), .out_rd_n(rdn1),
    .out_wr_n(wrn1), .out_ad_n(adn1), .out_ad_bus(bus1), .out_ad_oe(oe1), .state_now(st1)
  );

  logic       sel = 1'b0;
  logic       m_done, m_cs, m_rd, m_wr, m_adn, m_oe;
  logic [7:0] m_bus, m_dato;
  logic [2:0] m_st;

  always_comb begin
    if (sel) begin
      m_done = done1; m_cs = csn1; m_rd = rdn1; m_wr = wrn1; m_adn = adn1; m_oe = oe1;
      m_bus = bus1; m_dato = dato1; m_st = st1;
    end else begin
      m_done = done0; m_cs = csn0; m_rd = rdn0; m_wr = wrn0; m_adn = adn0; m_oe = oe0;
      m_bus = bus0; m_dato = dato0; m_st = st0;
    end
  end

  exp_t       exp_q [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_read [2];

  int a_len, a_pulse, d_len, d_wr, d_rd;
  bit a_err, d_err, inv_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_acc();
    a_len = 0; a_pulse = 0; d_len = 0; d_wr = 0; d_rd = 0;
    a_err = 1'b0; d_err = 1'b0; inv_err = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   have;
    clear_acc();
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_ctrl", 32'({m_done, m_cs, m_rd, m_wr, m_adn, m_oe}), 32'(6'b011110));
        chk("rst_bus", 32'(m_bus), 0);
        chk("rst_dato", 32'(m_dato), 0);
        chk("rst_state", 32'(m_st), 0);
        rd_ptr = wr_ptr;
        clear_acc();
      end else begin
        have = (rd_ptr != wr_ptr);
        if (have) e = exp_q[rd_ptr % 256];
        if (m_done) begin
          if (!have) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("addr_phase_len", 32'(a_len), 32'(e.phase));
            chk("addr_strobe_len", 32'(a_pulse), 32'(e.pulse));
            chk("addr_drive", 32'(a_err), 0);
            chk("data_phase_len", 32'(d_len), 32'(e.phase));
            chk(e.w_r ? "wr_strobe_len" : "rd_strobe_len", 32'(e.w_r ? d_wr : d_rd),
                32'(e.pulse));
            chk("other_strobe_len", 32'(e.w_r ? d_rd : d_wr), 0);
            chk("data_drive", 32'(d_err), 0);
            chk("strobe_rules", 32'(inv_err), 0);
            chk("dato_leido", 32'(m_dato), 32'(e.dato));
            chk("done_pins", 32'({m_cs, m_rd, m_wr, m_oe}), 32'(4'b1110));
            rd_ptr++;
          end
          clear_acc();
        end else if (have) begin
          if ((!m_rd && !m_wr) || (!m_rd && m_oe) || (m_cs && (!m_rd || !m_wr || m_oe)))
            inv_err = 1'b1;
          if (!m_cs) begin
            if (m_adn == 1'b0) begin
              a_len++;
              if (!m_wr) a_pulse++;
              if (!m_oe || m_bus != e.addr || !m_rd) a_err = 1'b1;
            end else begin
              d_len++;
              if (!m_wr) d_wr++;
              if (!m_rd) d_rd++;
              if (e.w_r) begin
                if (!m_oe || m_bus != e.data) d_err = 1'b1;
              end else if (m_oe) begin
                d_err = 1'b1;
              end
            end
          end
          if (cyc - e.acc > e.lat + 8) begin
            chk("done_timeout", 32'(cyc - e.acc), 32'(e.lat));
            rd_ptr++;
            clear_acc();
          end
        end else begin
          chk("idle_quiet", 32'({m_cs, m_rd, m_wr, m_oe, m_done}), 32'(5'b11100));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit s, bit e, bit w, logic [7:0] a, logic [7:0] d);
    if (s) begin
      en1 = e; wr1 = w; addr1 = a; data1 = d;
    end else begin
      en0 = e; wr0 = w; addr0 = a; data0 = d;
    end
  endtask

  // Expected result of one request, from the bus timing rules.
  task automatic start(bit s, bit w, logic [7:0] a, logic [7:0] d, logic [7:0] rv);
    exp_t e;
    int   ph;
    ph = s ? (S1 + P1 + H1) : (S0 + P0 + H0);
    if (s) rdval1 = rv; else rdval0 = rv;
    if (!w) last_read[s] = rv;
    e.w_r = w; e.addr = a; e.data = d; e.dato = last_read[s];
    e.acc = cyc; e.phase = ph; e.lat = 1 + 2 * ph; e.pulse = s ? P1 : P0;
    exp_q[wr_ptr % 256] = e;
    wr_ptr++;
    drive(s, 1'b1, w, a, d);
  endtask

  task automatic wait_done(bit s);
    int n = 0;
    while (((s ? done1 : done0) != 1'b1) && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic txn(bit s, bit w, logic [7:0] a, logic [7:0] d, logic [7:0] rv, bit wig);
    sel = s;
    start(s, w, a, d, rv);
    step();
    if (wig) drive(s, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    else     drive(s, 1'b0, w, a, d);
    wait_done(s);
    step();
  endtask

  initial begin
    bit         s, w, wig;
    logic [7:0] a, d, rv;
    last_read[0] = '0;
    last_read[1] = '0;
    reset = 1'b0;
    repeat (2) step();
    sel = 1'b1;
    repeat (2) step();
    sel = 1'b0;
    reset = 1'b1;
    step();

    txn(1'b0, 1'b1, 8'h21, 8'h45, 8'h00, 1'b0);
    txn(1'b0, 1'b0, 8'hF0, 8'h00, 8'h3C, 1'b0);

    // Sequencer-style run: en held, address stepped on each done edge.
    start(1'b0, 1'b1, 8'h21, 8'h10, 8'h00);
    for (int i = 1; i < 3; i++) begin
      step();
      wait_done(1'b0);
      step();
      start(1'b0, 1'b1, 8'(8'h21 + i), 8'(8'h10 + i), 8'h00);
    end
    step();
    wait_done(1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h23, 8'h12);
    step();

    // Drop en and change the address during ADDR_STROBE.
    start(1'b0, 1'b1, 8'h55, 8'h66, 8'h00);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b1, 8'h99, 8'h66);
    wait_done(1'b0);
    repeat (30) step();

    // Reset in the middle of a write's DATA_STROBE.
    start(1'b0, 1'b1, 8'hA1, 8'hB2, 8'h00);
    repeat (13) step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    last_read[0] = '0;
    last_read[1] = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    txn(1'b0, 1'b0, 8'h5A, 8'h00, 8'hC3, 1'b0);

    txn(1'b1, 1'b0, 8'h43, 8'h00, 8'h96, 1'b0);
    txn(1'b1, 1'b1, 8'h44, 8'h5E, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      s   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      wig = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      d   = 8'($urandom);
      rv  = 8'($urandom);
      txn(s, w, a, d, rv, wig);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
